// File: rtl/rr_grant_ctrl8_pkg.sv
// Shared definitions for the 8-way round-robin grant controller.
package rr_grant_ctrl8_pkg;
  localparam int NREQ = 8;
  localparam int IDXW = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;
endpackage

// File: rtl/rr_grant_ctrl8_onehot_enc8.sv
// 8-bit one-hot to 3-bit binary index encoder; all-zero input yields index 0.
module onehot_enc8
  import rr_grant_ctrl8_pkg::*;
(
  input  logic [NREQ-1:0] i_onehot,
  output logic [IDXW-1:0] o_idx
);

  always_comb begin
    o_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (i_onehot[i]) o_idx = o_idx | IDXW'(i);
    end
  end

endmodule

// File: rtl/rr_grant_ctrl8.sv
// Round-robin arbiter sharing one resource among 8 requesters, with optional
// maximum-hold timeout and a mandatory idle cycle between grants.
module rr_grant_ctrl8
  import rr_grant_ctrl8_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNTW     = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid,
  output logic            timeout
);

  localparam logic [CNTW-1:0] LP_HOLD_LAST = CNTW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t          r_state;
  logic [IDXW-1:0] r_ptr;
  logic [IDXW-1:0] r_idx;
  logic [CNTW-1:0] r_hold;
  logic [NREQ-1:0] r_grant;
  logic            r_valid;
  logic            r_timeout;

  logic [NREQ-1:0] w_rot;
  logic [NREQ-1:0] w_pick;
  logic [NREQ-1:0] w_sel;
  logic [NREQ-1:0] w_next_grant;
  logic [IDXW-1:0] w_next_idx;
  logic            w_start;
  logic            w_held_req;
  logic            w_hold_last;

  // Rotation done with 3-bit index arithmetic so the modulo-8 wrap is implicit.
  always_comb begin
    w_rot = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_rot[i] = req[IDXW'(i) + r_ptr];
    end
  end

  assign w_pick = w_rot & (~w_rot + NREQ'(1));

  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_sel[IDXW'(i) + r_ptr] = w_pick[i];
    end
  end

  assign w_start      = (r_state == ST_IDLE) && en && (|req);
  assign w_next_grant = w_start ? w_sel : '0;
  assign w_held_req   = req[r_idx];
  assign w_hold_last  = (MAX_HOLD != 0) && (r_hold == LP_HOLD_LAST);

  onehot_enc8 u_enc (
    .i_onehot (w_next_grant),
    .o_idx    (w_next_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_hold    <= '0;
      r_grant   <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_grant <= w_next_grant;
            r_idx   <= w_next_idx;
            r_valid <= 1'b1;
            r_hold  <= '0;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Release takes priority: timeout only flags when the request is still up.
          if (!w_held_req || w_hold_last) begin
            r_grant   <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_ptr     <= r_idx + IDXW'(1);
            r_timeout <= w_held_req;
            r_state   <= ST_IDLE;
          end else begin
            r_hold <= r_hold + CNTW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_idx   = r_idx;
  assign grant_valid = r_valid;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_grant_ctrl8.sv
// Directed testbench for rr_grant_ctrl8 (default instance plus a MAX_HOLD=4 instance).
module tb_rr_grant_ctrl8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] req4 = '0;

  logic [7:0] grant, grant4;
  logic [2:0] grant_idx, grant_idx4;
  logic       grant_valid, grant_valid4;
  logic       timeout, timeout4;

  logic [12:0] obs, obs4;
  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [12:0] IDLE = 13'h0000;
  localparam logic [12:0] TOUT = 13'h0001;

  always #5 clk = ~clk;

  rr_grant_ctrl8 #(.MAX_HOLD(16), .CNTW(5)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid), .timeout(timeout)
  );

  rr_grant_ctrl8 #(.MAX_HOLD(4), .CNTW(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req4),
    .grant(grant4), .grant_idx(grant_idx4), .grant_valid(grant_valid4), .timeout(timeout4)
  );

  assign obs  = {grant, grant_idx, grant_valid, timeout};
  assign obs4 = {grant4, grant_idx4, grant_valid4, timeout4};

  // Expected {grant, idx, valid, timeout} for an active grant to requester k.
  function automatic logic [12:0] gv(input int k);
    logic [7:0] oh;
    logic [2:0] ix;
    oh = 8'b1 << k;
    ix = 3'(k);
    return {oh, ix, 1'b1, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 8'hFF;
    req4  = 8'hFF;
    repeat (2) tick();
    n_tests++;
    if (obs !== IDLE) begin n_fail++; $display("FAIL reset_state: got %h want %h", obs, IDLE); end
    n_tests++;
    if (obs4 !== IDLE) begin n_fail++; $display("FAIL reset_state4: got %h want %h", obs4, IDLE); end
    req  = '0;
    req4 = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    reset_pulse();
    en  = 1'b1;
    req = 8'h04;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++;
      if (obs !== gv(2)) begin n_fail++; $display("FAIL single_hold c%0d: got %h want %h", c, obs, gv(2)); end
    end
    req = 8'h00;
    tick();
    n_tests++;
    if (obs !== IDLE) begin n_fail++; $display("FAIL single_release: got %h want %h", obs, IDLE); end
    // ptr should now be 3: with req 2 and 3 pending, 3 wins.
    req = 8'h0C;
    tick();
    n_tests++;
    if (obs !== gv(3)) begin n_fail++; $display("FAIL single_ptr: got %h want %h", obs, gv(3)); end
    req = 8'h00;
    tick();
  endtask

  task automatic test_all_rolling();
    int k;
    reset_pulse();
    en  = 1'b1;
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      k = g % 8;
      tick();
      n_tests++;
      if (obs !== gv(k)) begin n_fail++; $display("FAIL rr_first g%0d: got %h want %h", g, obs, gv(k)); end
      tick();
      n_tests++;
      if (obs !== gv(k)) begin n_fail++; $display("FAIL rr_second g%0d: got %h want %h", g, obs, gv(k)); end
      req = ~(8'b1 << k);
      tick();
      n_tests++;
      if (obs !== IDLE) begin n_fail++; $display("FAIL rr_gap g%0d: got %h want %h", g, obs, IDLE); end
      req = 8'hFF;
    end
    req = 8'h00;
    tick();
  endtask

  task automatic test_wrap();
    reset_pulse();
    en  = 1'b1;
    req = 8'h20;
    tick();
    n_tests++;
    if (obs !== gv(5)) begin n_fail++; $display("FAIL wrap_setup: got %h want %h", obs, gv(5)); end
    req = 8'h00;
    tick();
    req = 8'h41;
    tick();
    n_tests++;
    if (obs !== gv(6)) begin n_fail++; $display("FAIL wrap_first6: got %h want %h", obs, gv(6)); end
    req = 8'h01;
    tick();
    req = 8'h41;
    tick();
    n_tests++;
    if (obs !== gv(0)) begin n_fail++; $display("FAIL wrap_then0: got %h want %h", obs, gv(0)); end
    req = 8'h40;
    tick();
    req = 8'h41;
    tick();
    n_tests++;
    if (obs !== gv(6)) begin n_fail++; $display("FAIL wrap_again6: got %h want %h", obs, gv(6)); end
    req = 8'h00;
    tick();
  endtask

  task automatic test_timeout();
    reset_pulse();
    en   = 1'b1;
    req  = 8'h00;
    req4 = 8'h81;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++;
      if (obs4 !== gv(0)) begin n_fail++; $display("FAIL to_hold0 c%0d: got %h want %h", c, obs4, gv(0)); end
    end
    tick();
    n_tests++;
    if (obs4 !== TOUT) begin n_fail++; $display("FAIL to_pulse0: got %h want %h", obs4, TOUT); end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++;
      if (obs4 !== gv(7)) begin n_fail++; $display("FAIL to_hold7 c%0d: got %h want %h", c, obs4, gv(7)); end
    end
    tick();
    n_tests++;
    if (obs4 !== TOUT) begin n_fail++; $display("FAIL to_pulse7: got %h want %h", obs4, TOUT); end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++;
      if (obs4 !== gv(0)) begin n_fail++; $display("FAIL to_back0 c%0d: got %h want %h", c, obs4, gv(0)); end
    end
    // Release on the last allowed cycle: must not be flagged as a timeout.
    req4 = 8'h80;
    tick();
    n_tests++;
    if (obs4 !== IDLE) begin n_fail++; $display("FAIL to_release_wins: got %h want %h", obs4, IDLE); end
    req4 = 8'h00;
    tick();
    n_tests++;
    if (obs4 !== IDLE) begin n_fail++; $display("FAIL to_quiet: got %h want %h", obs4, IDLE); end
  endtask

  task automatic test_en_gating();
    reset_pulse();
    en  = 1'b0;
    req = 8'h10;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_tests++;
      if (obs !== IDLE) begin n_fail++; $display("FAIL en_off c%0d: got %h want %h", c, obs, IDLE); end
    end
    en = 1'b1;
    tick();
    n_tests++;
    if (obs !== gv(4)) begin n_fail++; $display("FAIL en_on: got %h want %h", obs, gv(4)); end
    en  = 1'b0;
    req = 8'h1F;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_tests++;
      if (obs !== gv(4)) begin n_fail++; $display("FAIL en_keep c%0d: got %h want %h", c, obs, gv(4)); end
    end
    req = 8'h0F;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_tests++;
      if (obs !== IDLE) begin n_fail++; $display("FAIL en_no_new c%0d: got %h want %h", c, obs, IDLE); end
    end
    en = 1'b1;
    tick();
    n_tests++;
    if (obs !== gv(0)) begin n_fail++; $display("FAIL en_resume: got %h want %h", obs, gv(0)); end
    req = 8'h00;
    tick();
  endtask

  task automatic test_reset_mid_grant();
    reset_pulse();
    en  = 1'b1;
    req = 8'h02;
    tick();
    req = 8'h00;
    tick();
    req = 8'h20;
    tick();
    n_tests++;
    if (obs !== gv(5)) begin n_fail++; $display("FAIL rst_setup: got %h want %h", obs, gv(5)); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs !== IDLE) begin n_fail++; $display("FAIL rst_async: got %h want %h", obs, IDLE); end
    req = 8'h21;
    #1;
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (obs !== gv(0)) begin n_fail++; $display("FAIL rst_ptr0: got %h want %h", obs, gv(0)); end
    req = 8'h00;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_rolling();
    test_wrap();
    test_timeout();
    test_en_gating();
    test_reset_mid_grant();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
